// File: rtl/riscv_pkg.sv
// Shared RISC-V definitions: PC-control FSM states and redirect priority ranks.
package riscv_pkg;

  typedef enum logic [1:0] {
    ST_BOOT = 2'd0,
    ST_RUN  = 2'd1,
    ST_PEND = 2'd2
  } pcctrl_state_e;

  // Higher rank wins; a latched redirect is replaced only by a strictly higher rank.
  localparam logic [1:0] RANK_TRAP  = 2'd2;
  localparam logic [1:0] RANK_XRET  = 2'd1;
  localparam logic [1:0] RANK_REDIR = 2'd0;

endpackage

// File: rtl/riscv_pcctrl.sv
// Next-PC selection: boot vector, trap/xret/branch redirects with stall-time
// latching, and sequential 2/4-byte advance for compressed/full instructions.
module riscv_pcctrl
  import riscv_pkg::*;
#(
  parameter logic [63:0] RESET_VECTOR = 64'h101a2
) (
  input  logic          i_riscv_pcctrl_clk,
  input  logic          i_riscv_pcctrl_rst_n,
  input  logic [63:0]   i_riscv_pcctrl_pc,
  input  logic [1:0]    i_riscv_pcctrl_instr_lo,
  input  logic          i_riscv_pcctrl_fetch_valid,
  input  logic          i_riscv_pcctrl_stall,
  input  logic          i_riscv_pcctrl_trap_valid,
  input  logic [63:0]   i_riscv_pcctrl_trap_vector,
  input  logic          i_riscv_pcctrl_xret_valid,
  input  logic [63:0]   i_riscv_pcctrl_xret_pc,
  input  logic          i_riscv_pcctrl_redir_valid,
  input  logic [63:0]   i_riscv_pcctrl_redir_pc,
  output logic [63:0]   o_riscv_pcctrl_nextpc,
  output logic          o_riscv_pcctrl_stallpc,
  output logic          o_riscv_pcctrl_flush,
  output logic          o_riscv_pcctrl_pending,
  output pcctrl_state_e o_riscv_pcctrl_state
);

  pcctrl_state_e state;
  logic [63:0]   lat_target;
  logic [1:0]    lat_rank;

  logic          req_valid;
  logic [1:0]    req_rank;
  logic [63:0]   req_target;
  logic [63:0]   seq_pc;
  logic          req_beats_lat;

  // Winning same-cycle request; bit 0 is cleared here so every path sees an aligned target.
  always_comb begin
    req_valid  = 1'b0;
    req_rank   = RANK_REDIR;
    req_target = 64'd0;
    if (i_riscv_pcctrl_trap_valid) begin
      req_valid  = 1'b1;
      req_rank   = RANK_TRAP;
      req_target = {i_riscv_pcctrl_trap_vector[63:1], 1'b0};
    end else if (i_riscv_pcctrl_xret_valid) begin
      req_valid  = 1'b1;
      req_rank   = RANK_XRET;
      req_target = {i_riscv_pcctrl_xret_pc[63:1], 1'b0};
    end else if (i_riscv_pcctrl_redir_valid) begin
      req_valid  = 1'b1;
      req_rank   = RANK_REDIR;
      req_target = {i_riscv_pcctrl_redir_pc[63:1], 1'b0};
    end
  end

  assign req_beats_lat = req_valid && (req_rank > lat_rank);
  assign seq_pc = i_riscv_pcctrl_pc +
                  ((i_riscv_pcctrl_instr_lo == 2'b11) ? 64'd4 : 64'd2);

  always_ff @(posedge i_riscv_pcctrl_clk or negedge i_riscv_pcctrl_rst_n) begin
    if (!i_riscv_pcctrl_rst_n) begin
      state      <= ST_BOOT;
      lat_target <= 64'd0;
      lat_rank   <= RANK_REDIR;
    end else begin
      case (state)
        ST_BOOT: state <= ST_RUN;
        ST_RUN: begin
          if (req_valid && i_riscv_pcctrl_stall) begin
            state      <= ST_PEND;
            lat_target <= req_target;
            lat_rank   <= req_rank;
          end
        end
        ST_PEND: begin
          if (i_riscv_pcctrl_stall) begin
            if (req_beats_lat) begin
              lat_target <= req_target;
              lat_rank   <= req_rank;
            end
          end else begin
            state      <= ST_RUN;
            lat_target <= 64'd0;
            lat_rank   <= RANK_REDIR;
          end
        end
        default: state <= ST_BOOT;
      endcase
    end
  end

  always_comb begin
    o_riscv_pcctrl_nextpc  = i_riscv_pcctrl_pc;
    o_riscv_pcctrl_stallpc = 1'b0;
    o_riscv_pcctrl_flush   = 1'b0;
    case (state)
      ST_RUN: begin
        if (i_riscv_pcctrl_stall) begin
          o_riscv_pcctrl_stallpc = 1'b1;
        end else if (req_valid) begin
          o_riscv_pcctrl_nextpc = req_target;
          o_riscv_pcctrl_flush  = 1'b1;
        end else if (!i_riscv_pcctrl_fetch_valid) begin
          o_riscv_pcctrl_stallpc = 1'b1;
        end else begin
          o_riscv_pcctrl_nextpc = seq_pc;
        end
      end
      ST_PEND: begin
        if (i_riscv_pcctrl_stall) begin
          o_riscv_pcctrl_stallpc = 1'b1;
        end else begin
          o_riscv_pcctrl_nextpc = req_beats_lat ? req_target : lat_target;
          o_riscv_pcctrl_flush  = 1'b1;
        end
      end
      default: begin
        o_riscv_pcctrl_nextpc = RESET_VECTOR;
        o_riscv_pcctrl_flush  = 1'b1;
      end
    endcase
  end

  assign o_riscv_pcctrl_pending = (state == ST_PEND);
  assign o_riscv_pcctrl_state   = state;

endmodule

// File: tb/tb_riscv_pcctrl.sv
// Directed bench for riscv_pcctrl: boot, sequential advance, priority, stall latching, reset in PEND.
module tb_riscv_pcctrl;
  import riscv_pkg::*;

  logic          clk;
  logic          rst_n;
  logic [63:0]   pc;
  logic [1:0]    instr_lo;
  logic          fetch_valid;
  logic          stall;
  logic          trap_valid;
  logic [63:0]   trap_vector;
  logic          xret_valid;
  logic [63:0]   xret_pc;
  logic          redir_valid;
  logic [63:0]   redir_pc;
  logic [63:0]   nextpc;
  logic          stallpc;
  logic          flush;
  logic          pending;
  pcctrl_state_e state;

  int errors = 0;
  int checks = 0;

  riscv_pcctrl #(.RESET_VECTOR(64'h101a2)) dut (
    .i_riscv_pcctrl_clk         (clk),
    .i_riscv_pcctrl_rst_n       (rst_n),
    .i_riscv_pcctrl_pc          (pc),
    .i_riscv_pcctrl_instr_lo    (instr_lo),
    .i_riscv_pcctrl_fetch_valid (fetch_valid),
    .i_riscv_pcctrl_stall       (stall),
    .i_riscv_pcctrl_trap_valid  (trap_valid),
    .i_riscv_pcctrl_trap_vector (trap_vector),
    .i_riscv_pcctrl_xret_valid  (xret_valid),
    .i_riscv_pcctrl_xret_pc     (xret_pc),
    .i_riscv_pcctrl_redir_valid (redir_valid),
    .i_riscv_pcctrl_redir_pc    (redir_pc),
    .o_riscv_pcctrl_nextpc      (nextpc),
    .o_riscv_pcctrl_stallpc     (stallpc),
    .o_riscv_pcctrl_flush       (flush),
    .o_riscv_pcctrl_pending     (pending),
    .o_riscv_pcctrl_state       (state)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] observed, input logic [63:0] expected);
    checks++;
    assert (observed === expected)
    else begin
      errors++;
      $error("FAIL %s: observed=%h expected=%h", tag, observed, expected);
    end
  endtask

  // Advance one clock edge, then settle 1 time unit past it.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic outs(input string tag, input logic [63:0] exp_pc, input logic exp_stall,
                      input logic exp_flush, input logic exp_pend);
    check({tag, ".nextpc"},  nextpc,  exp_pc);
    check({tag, ".stallpc"}, {63'd0, stallpc}, {63'd0, exp_stall});
    check({tag, ".flush"},   {63'd0, flush},   {63'd0, exp_flush});
    check({tag, ".pending"}, {63'd0, pending}, {63'd0, exp_pend});
  endtask

  task automatic clear_reqs();
    trap_valid  = 1'b0;
    xret_valid  = 1'b0;
    redir_valid = 1'b0;
  endtask

  initial begin
    rst_n = 1'b0; pc = 64'h101a2; instr_lo = 2'b11; fetch_valid = 1'b1; stall = 1'b0;
    trap_vector = 64'h0; xret_pc = 64'h0; redir_pc = 64'h0;
    clear_reqs();
    #1;
    outs("reset", 64'h101a2, 1'b0, 1'b1, 1'b0);
    check("reset.state", {62'd0, state}, {62'd0, ST_BOOT});
    step(); step();
    rst_n = 1'b1;
    #1;
    outs("boot_cycle0", 64'h101a2, 1'b0, 1'b1, 1'b0);
    step();
    outs("run_cycle1", 64'h101a6, 1'b0, 1'b0, 1'b0);
    check("run.state", {62'd0, state}, {62'd0, ST_RUN});

    // Sequential advance: compressed vs full-width instruction.
    pc = 64'h2000; instr_lo = 2'b01; #1;
    outs("seq_c", 64'h2002, 1'b0, 1'b0, 1'b0);
    instr_lo = 2'b11; #1;
    outs("seq_full", 64'h2004, 1'b0, 1'b0, 1'b0);

    // No valid fetch holds the PC.
    fetch_valid = 1'b0; #1;
    outs("no_fetch", 64'h2000, 1'b1, 1'b0, 1'b0);
    fetch_valid = 1'b1;

    // Stall with no redirect stays in RUN.
    stall = 1'b1; #1;
    outs("stall_idle", 64'h2000, 1'b1, 1'b0, 1'b0);
    step();
    outs("stall_idle_next", 64'h2000, 1'b1, 1'b0, 1'b0);
    stall = 1'b0;

    // All three sources at once: trap wins, zero latency.
    trap_valid = 1'b1; trap_vector = 64'h8000_0000;
    xret_valid = 1'b1; xret_pc = 64'h3000;
    redir_valid = 1'b1; redir_pc = 64'h4001;
    #1;
    outs("prio_trap", 64'h8000_0000, 1'b0, 1'b1, 1'b0);
    trap_valid = 1'b0; #1;
    outs("prio_xret", 64'h3000, 1'b0, 1'b1, 1'b0);
    xret_valid = 1'b0; #1;
    outs("redir_align", 64'h4000, 1'b0, 1'b1, 1'b0);
    step();
    outs("after_redir", 64'h4000, 1'b0, 1'b1, 1'b0);
    clear_reqs(); #1;
    outs("back_to_seq", 64'h2004, 1'b0, 1'b0, 1'b0);

    // Redirect under stall, then a trap overrides it while still stalled.
    stall = 1'b1; redir_valid = 1'b1; redir_pc = 64'h4000; #1;
    outs("latch_redir", 64'h2000, 1'b1, 1'b0, 1'b0);
    step();
    redir_valid = 1'b0; trap_valid = 1'b1; trap_vector = 64'h8000_0000; #1;
    outs("pend_trap", 64'h2000, 1'b1, 1'b0, 1'b1);
    step();
    trap_valid = 1'b0; #1;
    outs("pend_hold", 64'h2000, 1'b1, 1'b0, 1'b1);
    step();
    outs("pend_hold2", 64'h2000, 1'b1, 1'b0, 1'b1);
    stall = 1'b0; #1;
    outs("pend_release", 64'h8000_0000, 1'b0, 1'b1, 1'b1);
    step();
    outs("post_release", 64'h2004, 1'b0, 1'b0, 1'b0);

    // Lower-rank request during PEND is dropped.
    stall = 1'b1; xret_valid = 1'b1; xret_pc = 64'h3000; #1;
    step();
    xret_valid = 1'b0; redir_valid = 1'b1; redir_pc = 64'h5000; #1;
    step();
    redir_valid = 1'b0; stall = 1'b0; #1;
    outs("drop_lower", 64'h3000, 1'b0, 1'b1, 1'b1);
    step();

    // Release with a same-cycle higher-rank request takes the new target.
    stall = 1'b1; redir_valid = 1'b1; redir_pc = 64'h4000; #1;
    step();
    redir_valid = 1'b0; stall = 1'b0; xret_valid = 1'b1; xret_pc = 64'h6000; #1;
    outs("release_override", 64'h6000, 1'b0, 1'b1, 1'b1);
    step();
    clear_reqs();

    // Reset in PEND discards the latched target.
    stall = 1'b1; redir_valid = 1'b1; redir_pc = 64'h4000; #1;
    step();
    redir_valid = 1'b0; #1;
    check("pend_before_rst", {63'd0, pending}, 64'd1);
    rst_n = 1'b0; #1;
    outs("rst_in_pend", 64'h101a2, 1'b0, 1'b1, 1'b0);
    #2;
    rst_n = 1'b1; stall = 1'b0; #1;
    outs("rst_release", 64'h101a2, 1'b0, 1'b1, 1'b0);
    step();
    outs("after_rst_run", 64'h2004, 1'b0, 1'b0, 1'b0);

    // 64-bit wrap of the sequential PC.
    pc = 64'hFFFF_FFFF_FFFF_FFFC; instr_lo = 2'b11; #1;
    outs("wrap4", 64'h0, 1'b0, 1'b0, 1'b0);
    pc = 64'hFFFF_FFFF_FFFF_FFFE; instr_lo = 2'b00; #1;
    outs("wrap2", 64'h0, 1'b0, 1'b0, 1'b0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/riscv_pcctrl.md
RISCV_PCCTRL -- requirements
Module: riscv_pcctrl

Interface
REQ-001 SHALL have parameter RESET_VECTOR, default 64'h101a2, the PC value presented after reset.
REQ-002 SHALL have i_riscv_pcctrl_clk  input  1  the single clock.
REQ-003 SHALL have i_riscv_pcctrl_rst_n  input  1  reset, asynchronous, active-low.
REQ-004 SHALL have i_riscv_pcctrl_pc  input  64  current PC from the PC register.
REQ-005 SHALL have i_riscv_pcctrl_instr_lo  input  2  bits [1:0] of the fetched instruction.
REQ-006 SHALL have i_riscv_pcctrl_fetch_valid  input  1  fetched instruction is valid.
REQ-007 SHALL have i_riscv_pcctrl_stall  input  1  pipeline hazard stall.
REQ-008 SHALL have i_riscv_pcctrl_trap_valid / i_riscv_pcctrl_trap_vector  input  1/64  trap request and target.
REQ-009 SHALL have i_riscv_pcctrl_xret_valid / i_riscv_pcctrl_xret_pc  input  1/64  mret/sret request and target.
REQ-010 SHALL have i_riscv_pcctrl_redir_valid / i_riscv_pcctrl_redir_pc  input  1/64  EX-stage branch/jump redirect and target.
REQ-011 SHALL have o_riscv_pcctrl_nextpc  output  64  next PC to the PC register.
REQ-012 SHALL have o_riscv_pcctrl_stallpc  output  1  hold the PC register.
REQ-013 SHALL have o_riscv_pcctrl_flush  output  1  flush IF/ID on the redirect cycle.
REQ-014 SHALL have o_riscv_pcctrl_pending  output  1  a redirect is latched awaiting stall release.

Function
REQ-015 SHALL implement states BOOT, RUN, PEND.
REQ-016 BOOT: nextpc = RESET_VECTOR, stallpc = 0, flush = 1; transitions to RUN after one cycle unconditionally.
REQ-017 Source priority, highest first: trap > xret > redir > sequential.
REQ-018 Sequential nextpc = pc + 2 when instr_lo != 2'b11, else pc + 4, with 64-bit modulo wrap (64'hFFFF_FFFF_FFFF_FFFE + 2 = 0).
REQ-019 When fetch_valid = 0 and no redirect is present in RUN, stallpc = 1 and nextpc = pc.
REQ-020 RUN, stall = 0, redirect present: nextpc = winning target with bit 0 forced to 0, flush = 1 in the same cycle (zero latency).
REQ-021 RUN, stall = 1, redirect present: latch the winning target and its priority rank, stallpc = 1, flush = 0, next state PEND.
REQ-022 PEND: stallpc = 1 while stall = 1; a new request of strictly higher rank overwrites the latch; equal or lower rank is dropped.
REQ-023 PEND, stall = 0: nextpc = latched target (or a same-cycle strictly-higher-rank request), stallpc = 0, flush = 1, next state RUN, latch cleared.
REQ-024 A trap shall always be accepted, even during stall, and never dropped.
REQ-025 pending = 1 exactly while in PEND.
REQ-026 No redirect, stall = 1, in RUN: stallpc = 1, flush = 0, state remains RUN.

Reset
REQ-027 On rst_n low, asynchronously: state = BOOT, latch cleared, pending = 0, nextpc = RESET_VECTOR, stallpc = 0, flush = 1.
REQ-028 Reset asserted in PEND shall discard the latched target; after release, the first nextpc shall be RESET_VECTOR.

Structure
REQ-029 State enum (pcctrl_state_e) and rank constants (TRAP = 2, XRET = 1, REDIR = 0) SHALL reside in shared package riscv_pkg.
REQ-030 SHALL be a single module with no sub-module; target is 120-250 lines of RTL.

Verification
REQ-031 Reset release, pc = 64'h101a2, instr_lo = 2'b11 -> cycle 0 nextpc = 64'h101a2 with flush = 1; cycle 1 nextpc = 64'h101a6.
REQ-032 pc = 64'h2000, instr_lo = 2'b01 -> nextpc = 64'h2002; instr_lo = 2'b11 -> 64'h2004.
REQ-033 Same-cycle trap_vector = 64'h8000_0000, xret_pc = 64'h3000, redir_pc = 64'h4001 -> nextpc = 64'h8000_0000, flush = 1.
REQ-034 stall = 1 with redir_pc = 64'h4000; next cycle trap_vector = 64'h8000_0000 still under stall; stall drops 2 cycles later -> pending = 1 throughout, stallpc = 1, then nextpc = 64'h8000_0000, flush = 1 for one cycle, redirect to 64'h4000 lost.
REQ-035 In PEND with latched 64'h4000, assert rst_n = 0 mid-stall -> pending = 0 immediately; after release nextpc = 64'h101a2.
REQ-036 pc = 64'hFFFF_FFFF_FFFF_FFFC, instr_lo = 2'b11 -> nextpc = 64'h0.
